bin_to_bcd_serial: RTL and testbench
====================================

// Module: bin_to_bcd_serial
// PURPOSE
//   Sequential double-dabble binary-to-BCD converter. It sits directly upstream of the per-digit
//   seven_display decoders in the score path and replaces wide combinational /10 and %10 logic.
//   It converts one IN_WIDTH-bit value per start request, one bit per clock, and presents
//   DIGITS packed BCD nibbles plus a leading-zero blank mask.
// PARAMETERS
//   IN_WIDTH  20  binary input width; 20 bits covers 999999
//   DIGITS    6   number of BCD output digits; max displayable value is 10^DIGITS-1
// PORTS
//   clk        in   1            single system clock, rising edge
//   rst        in   1            asynchronous, active-high reset
//   start      in   1            request conversion of bin_in; sampled only in IDLE
//   bin_in     in   IN_WIDTH     binary value, captured on the accepted start edge
//   busy       out  1            high from the accepted start through the DONE cycle
//   done       out  1            one-cycle pulse; bcd_out/overflow/lead_zero update on this cycle
//   overflow   out  1            captured bin_in > 10^DIGITS-1; held until next done
//   bcd_out    out  4*DIGITS     packed BCD result; digit i at [4i+3:4i], digit 0 = units
//   lead_zero  out  DIGITS       bit i=1 -> digit i is a leading zero (blank it); bit 0 always 0
// BEHAVIOUR
//   - Reset, asserted at any time including mid-conversion:
//       FSM=IDLE; busy=0, done=0, overflow=0, bcd_out=0, lead_zero={DIGITS-1{1'b1},1'b0}.
//       Internal shift and count registers clear.
//   - FSM IDLE -> SHIFT -> DONE -> IDLE.
//     IDLE:  start=1 latches bin_in into the low part of a working register of width
//            4*DIGITS+IN_WIDTH, with BCD part = 0. It also latches ovf_q = (bin_in > 10^DIGITS-1),
//            loads cnt = IN_WIDTH, and moves to SHIFT. busy rises on the next edge.
//     SHIFT: each cycle, every BCD nibble >= 5 gets +3 (combinational, all nibbles in parallel).
//            The whole register then shifts left by 1 and cnt decrements.
//            After exactly IN_WIDTH SHIFT cycles (cnt reaches 1 -> 0), go to DONE.
//     DONE:  for one cycle, done=1 and the output registers load.
//            bcd_out = ovf_q ? all nibbles 4'h9 : working BCD part. overflow = ovf_q.
//            lead_zero[i] = 1 iff all digits i..DIGITS-1 are zero (i>=1); bit 0 forced 0.
//            Next state IDLE.
//   - Latency: start sampled at edge N -> done high during the cycle after edge N+IN_WIDTH+1.
//     That is IN_WIDTH+2 cycles of busy; 22 cycles at the defaults.
//   - Outputs bcd_out, overflow and lead_zero are registered.
//     They change only in the DONE cycle or on reset, and hold otherwise (glitch-free display).
//   - start while busy (SHIFT or DONE) is ignored and not queued. bin_in changing while busy has no effect.
//   - start held high continuously gives back-to-back conversions.
//     The next one is accepted in the IDLE cycle after DONE.
//   - Width rules: nibble add-3 is 4-bit with no carry out (inputs are <= 9 by construction).
//     The 10^DIGITS-1 compare is done at max(IN_WIDTH, ceil(log2(10^DIGITS))) bits to avoid truncation.
//   - No combinational path from inputs to outputs.
// STRUCTURE
//   - Shared package pong_display_pkg:
//       BCD_W = 4, DEFAULT_DIGITS = 6,
//       function bcd_max(DIGITS) returning 10^DIGITS-1,
//       state encoding localparams S_IDLE/S_SHIFT/S_DONE.
//   - One sub-module, bcd_add3: 4-bit in/out combinational correction cell (in>=5 ? in+3 : in).
//     It is instantiated DIGITS times via generate.
//   - bcd_out nibbles feed seven_display instances directly; lead_zero gates their blanking.
// TESTING
//   1. bin_in=0, start pulse -> done after 22 cycles; bcd_out=24'h000000, lead_zero=6'b111110, overflow=0.
//   2. bin_in=123456 -> bcd_out=24'h123456, lead_zero=6'b000000; then bin_in=42 -> 24'h000042, lead_zero=6'b111100.
//   3. bin_in=999999 -> 24'h999999, overflow=0; bin_in=1000000 and 20'hFFFFF -> 24'h999999, overflow=1.
//   4. start at cycle 0 (bin_in=7), start again at cycle 5 with bin_in=9
//      -> exactly one done, at cycle 22, with 24'h000007; busy stays high throughout.
//   5. rst pulsed at cycle 10 of a conversion of 555555
//      -> busy=0, done never pulses, bcd_out=0, lead_zero=6'b111110; a fresh start then completes normally.
//   6. start held high with inputs 1, 2, 3 changing each DONE
//      -> done pulses every 23 cycles, outputs 1, 2, 3 in order, and outputs hold between pulses.

Source files
------------

// File: rtl/pong_display_pkg.sv
// Shared definitions for the score display path.
// Holds the BCD nibble width, the default digit count, the converter state
// encoding and a helper that gives the largest value a digit count can show.
package pong_display_pkg;

  localparam int BCD_W          = 4;
  localparam int DEFAULT_DIGITS = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Largest value representable with 'digits' decimal digits (10^digits - 1).
  // Evaluated at elaboration time only, so the loop costs no logic.
  function automatic logic [63:0] bcd_max(input int digits);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_serial_if.sv
// Bundle between a producer of binary values and the serial BCD converter.
//   start     : request a conversion of bin_in
//   bin_in    : binary value to convert
//   busy      : conversion in progress (including the done cycle)
//   done      : one-cycle pulse when the result registers update
//   overflow  : captured value exceeded the displayable range
//   bcd_out   : packed BCD digits, digit 0 = units in the low nibble
//   lead_zero : per-digit blanking mask for leading zeros
// master = requester side, slave = converter side.
interface bin_to_bcd_serial_if
  import pong_display_pkg::*;
#(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = DEFAULT_DIGITS
);

  logic                      start;
  logic [IN_WIDTH-1:0]       bin_in;
  logic                      busy;
  logic                      done;
  logic                      overflow;
  logic [BCD_W*DIGITS-1:0]   bcd_out;
  logic [DIGITS-1:0]         lead_zero;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, bcd_out, lead_zero
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, bcd_out, lead_zero
  );

endinterface

// File: rtl/bin_to_bcd_serial_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
//   digit_in  : current BCD nibble (0..9 by construction)
//   digit_out : corrected nibble
module bcd_add3 (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Input never exceeds 9, so the 4-bit sum cannot carry out.
  assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_serial.sv
// Sequential double-dabble binary-to-BCD converter for the score display.
// Converts one value per request, one bit per clock, and presents packed BCD
// digits plus a leading-zero blanking mask on registered outputs.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of bin_to_bcd_serial_if (start/bin_in in,
//         busy/done/overflow/bcd_out/lead_zero out)
module bin_to_bcd_serial
  import pong_display_pkg::*;
#(
  parameter int IN_WIDTH = 20,
  parameter int DIGITS   = DEFAULT_DIGITS
) (
  input  logic               clk,
  input  logic               rst,
  bin_to_bcd_serial_if.slave bus
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int WORK_W   = BCD_BITS + IN_WIDTH;
  localparam int CNT_W    = $clog2(IN_WIDTH + 1);

  // The range compare must be wide enough for both the input and the
  // decimal limit, otherwise one of them would be truncated.
  localparam logic [63:0] MAX_VAL64 = bcd_max(DIGITS);
  localparam int          MAX_BITS  = $clog2(MAX_VAL64 + 64'd1);
  localparam int          CMP_W     = (IN_WIDTH > MAX_BITS) ? IN_WIDTH : MAX_BITS;
  localparam logic [CMP_W-1:0] MAX_VAL = MAX_VAL64[CMP_W-1:0];

  localparam logic [DIGITS-1:0] LZ_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

  state_t              state;
  state_t              state_next;
  logic [WORK_W-1:0]   work_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
  logic                busy_q;
  logic                done_q;
  logic                overflow_q;
  logic [BCD_BITS-1:0] bcd_q;
  logic [DIGITS-1:0]   lz_q;

  logic                accept;
  logic [BCD_BITS-1:0] bcd_adj;
  logic [WORK_W-1:0]   work_shifted;
  logic [CMP_W-1:0]    bin_ext;
  logic [BCD_BITS-1:0] bcd_result;
  logic [DIGITS-1:0]   lz_result;
  logic                zero_run;

  // A request is taken only when idle and not still showing the previous
  // done pulse; busy covers the done cycle, so back-to-back requests land
  // on the idle cycle that follows it.
  assign accept  = (state == S_IDLE) && bus.start && !busy_q;
  assign bin_ext = CMP_W'(bus.bin_in);

  // All BCD nibbles are corrected in parallel before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_in  (work_q[IN_WIDTH + BCD_W*g +: BCD_W]),
      .digit_out (bcd_adj[BCD_W*g +: BCD_W])
    );
  end

  assign work_shifted = {bcd_adj[BCD_BITS-2:0], work_q[IN_WIDTH-1:0], 1'b0};

  // Out-of-range values saturate to all nines so the display shows a
  // recognisable ceiling rather than garbage digits.
  assign bcd_result = ovf_q ? {DIGITS{4'h9}} : work_q[WORK_W-1:IN_WIDTH];

  // Digit i is blank when it and every digit above it are zero; the units
  // digit is never blanked so a value of zero still shows "0".
  always_comb begin
    lz_result = '0;
    zero_run  = 1'b1;
    for (int i = DIGITS-1; i >= 1; i--) begin
      zero_run     = zero_run & (bcd_result[BCD_W*i +: BCD_W] == 4'd0);
      lz_result[i] = zero_run;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one shift per input bit, then a single result cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_W'(1)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Working register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            work_q <= {{BCD_BITS{1'b0}}, bus.bin_in};
            ovf_q  <= (bin_ext > MAX_VAL);
            cnt_q  <= CNT_W'(IN_WIDTH);
          end
        end
        S_SHIFT: begin
          work_q <= work_shifted;
          cnt_q  <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Output registers load at the end of the result state, so the new
  // digits and the done pulse appear together in the following cycle and
  // the display never sees a partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      bcd_q      <= '0;
      lz_q       <= LZ_RESET;
    end else begin
      done_q <= (state == S_DONE);
      if (accept) begin
        busy_q <= 1'b1;
      end else if (done_q) begin
        busy_q <= 1'b0;
      end
      if (state == S_DONE) begin
        bcd_q      <= bcd_result;
        overflow_q <= ovf_q;
        lz_q       <= lz_result;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overflow  = overflow_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.lead_zero = lz_q;

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial: directed scenarios plus random
// values compared against an arithmetic decimal model.
module tb_bin_to_bcd_serial;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bin_to_bcd_serial_if #(.IN_WIDTH(20), .DIGITS(6)) dut_bus ();

  bin_to_bcd_serial #(.IN_WIDTH(20), .DIGITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop so a stuck design can never hang the run.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Decimal digits by repeated division; saturates above 999999.
  function automatic logic [23:0] modelBcd(input int unsigned v);
    logic [23:0] r;
    int unsigned x;
    if (v > 999999) return 24'h999999;
    r = '0;
    x = v;
    for (int d = 0; d < 6; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i (i>=1) is blank when the shown value is below 10^i.
  function automatic logic [5:0] modelLz(input int unsigned v);
    logic [5:0]  lz;
    int unsigned capped;
    int unsigned p;
    capped = (v > 999999) ? 999999 : v;
    lz = '0;
    p  = 1;
    for (int i = 1; i < 6; i++) begin
      p = p * 10;
      lz[i] = (capped < p);
    end
    return lz;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a value with a one-cycle start pulse; returns at the negedge
  // of the first cycle after the accepting edge.
  task automatic applyStimulus(input int unsigned v);
    @(negedge clk);
    dut_bus.bin_in = 20'(v);
    dut_bus.start  = 1'b1;
    @(negedge clk);
    dut_bus.start  = 1'b0;
  endtask

  // Counts cycles (the current one being cycle 1) until done, bounded.
  task automatic waitDone(output int cycles);
    cycles = 1;
    while (!dut_bus.done && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic runAndCheck(input int unsigned v, input string tag);
    int cyc;
    applyStimulus(v);
    checkOutput({tag, "_busy"}, 32'(dut_bus.busy), 32'd1);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'd22);
    checkOutput({tag, "_bcd"}, 32'(dut_bus.bcd_out), 32'(modelBcd(v)));
    checkOutput({tag, "_lz"}, 32'(dut_bus.lead_zero), 32'(modelLz(v)));
    checkOutput({tag, "_ovf"}, 32'(dut_bus.overflow), 32'(v > 999999));
    @(negedge clk);
    checkOutput({tag, "_done_low"}, 32'(dut_bus.done), 32'd0);
    checkOutput({tag, "_idle"}, 32'(dut_bus.busy), 32'd0);
    checkOutput({tag, "_hold"}, 32'(dut_bus.bcd_out), 32'(modelBcd(v)));
  endtask

  initial begin
    int cyc;
    int done_cnt;
    int done_cyc;
    int busy_low;
    int hold_err;
    int idx;
    int last_cyc;
    int unsigned rv;
    logic [23:0] last_bcd;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    dut_bus.start  = 1'b0;
    dut_bus.bin_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(dut_bus.busy), 32'd0);
    checkOutput("rst_done", 32'(dut_bus.done), 32'd0);
    checkOutput("rst_ovf", 32'(dut_bus.overflow), 32'd0);
    checkOutput("rst_bcd", 32'(dut_bus.bcd_out), 32'd0);
    checkOutput("rst_lz", 32'(dut_bus.lead_zero), 32'b111110);
    rst = 1'b0;
    @(negedge clk);

    // Directed values including both sides of the range limit
    runAndCheck(0, "zero");
    runAndCheck(123456, "v123456");
    checkOutput("v123456_const", 32'(dut_bus.bcd_out), 32'h123456);
    runAndCheck(42, "v42");
    checkOutput("v42_lz_const", 32'(dut_bus.lead_zero), 32'b111100);
    runAndCheck(999999, "max");
    runAndCheck(1000000, "over1");
    runAndCheck(20'hFFFFF, "overmax");
    checkOutput("overmax_const", 32'(dut_bus.bcd_out), 32'h999999);

    // Second start while busy is ignored
    applyStimulus(7);
    done_cnt = 0;
    done_cyc = 0;
    busy_low = 0;
    for (int c = 1; c <= 50; c++) begin
      if (c == 5) begin
        dut_bus.bin_in = 20'd9;
        dut_bus.start  = 1'b1;
      end else if (c == 6) begin
        dut_bus.start  = 1'b0;
      end
      if (done_cnt == 0 && !dut_bus.busy) busy_low++;
      if (dut_bus.done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = c;
          checkOutput("busy_start_bcd", 32'(dut_bus.bcd_out), 32'h000007);
        end
      end
      @(negedge clk);
    end
    checkOutput("busy_start_dones", 32'(done_cnt), 32'd1);
    checkOutput("busy_start_cycle", 32'(done_cyc), 32'd22);
    checkOutput("busy_start_busy", 32'(busy_low), 32'd0);

    // Reset in the middle of a conversion
    applyStimulus(555555);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(dut_bus.busy), 32'd0);
    checkOutput("midrst_done", 32'(dut_bus.done), 32'd0);
    checkOutput("midrst_bcd", 32'(dut_bus.bcd_out), 32'd0);
    checkOutput("midrst_lz", 32'(dut_bus.lead_zero), 32'b111110);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (dut_bus.done) done_cnt++;
    end
    checkOutput("midrst_nodone", 32'(done_cnt), 32'd0);
    runAndCheck(314159, "after_rst");

    // Start held high: back-to-back conversions every 23 cycles
    @(negedge clk);
    dut_bus.bin_in = 20'd1;
    dut_bus.start  = 1'b1;
    idx      = 0;
    last_cyc = 0;
    hold_err = 0;
    last_bcd = dut_bus.bcd_out;
    for (int c = 1; c <= 90; c++) begin
      @(negedge clk);
      if (dut_bus.done && idx < 3) begin
        checkOutput($sformatf("b2b_val%0d", idx), 32'(dut_bus.bcd_out), 32'(modelBcd(idx + 1)));
        if (idx > 0) checkOutput($sformatf("b2b_period%0d", idx), 32'(c - last_cyc), 32'd23);
        last_cyc = c;
        last_bcd = dut_bus.bcd_out;
        idx++;
        dut_bus.bin_in = 20'(idx + 1);
        if (idx == 3) dut_bus.start = 1'b0;
      end else if (dut_bus.bcd_out !== last_bcd) begin
        hold_err++;
      end
    end
    checkOutput("b2b_count", 32'(idx), 32'd3);
    checkOutput("b2b_hold", 32'(hold_err), 32'd0);
    dut_bus.start = 1'b0;
    repeat (3) @(negedge clk);

    // Random values, half in range and half over the full input width
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) rv = $urandom_range(999999, 0);
      else            rv = $urandom & 32'h000F_FFFF;
      runAndCheck(rv, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
